inta_sequencer: RTL and testbench

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/inta_sequencer.sv | 160 ++++++++++++++++
 tb/tb_inta_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: issues INTA_n pulses, captures the vector byte, holds it until acked.
// Optional 3-pulse MCS-80 CALL sequence when INTA_MCS80_MODE_EN is defined.
module inta_sequencer #(
    parameter int unsigned PULSE_WIDTH = 2,
    parameter int unsigned GAP_WIDTH   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt_to_cpu,
    input  logic        interrupt_enable,
    input  logic [7:0]  internal_data_bus,
    input  logic        vector_ack,
`ifdef INTA_MCS80_MODE_EN
    input  logic        mcs80_mode,
    output logic [15:0] call_address,
    output logic        call_opcode_error,
`endif
    output logic        interrupt_acknowledge_n,
    output logic [7:0]  vector_number,
    output logic        vector_valid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACK_LOW, ACK_GAP, DONE} state_t;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_WIDTH - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_WIDTH - 1);
    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    state_t      state_q, state_d;
    logic [1:0]  pulse_q, pulse_d;
    logic [3:0]  phase_q, phase_d;
    logic        inta_n_q, inta_n_d;
    logic [7:0]  vector_q, vector_d;
    logic        valid_q, valid_d;
    logic        last_pulse;

`ifdef INTA_MCS80_MODE_EN
    logic        mode_q, mode_d;
    logic [15:0] call_q, call_d;
    logic        err_q, err_d;

    assign last_pulse = (pulse_q == (mode_q ? 2'd2 : 2'd1));
`else
    assign last_pulse = (pulse_q == 2'd1);
`endif

    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        phase_d  = phase_q;
        vector_d = vector_q;
`ifdef INTA_MCS80_MODE_EN
        mode_d   = mode_q;
        call_d   = call_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                pulse_d = 2'd0;
                phase_d = 4'd0;
                if (interrupt_to_cpu && interrupt_enable) begin
                    state_d = ACK_LOW;
`ifdef INTA_MCS80_MODE_EN
                    mode_d  = mcs80_mode;
                    err_d   = 1'b0;
`endif
                end
            end
            ACK_LOW: begin
                if (phase_q == PULSE_LAST) begin
                    phase_d = 4'd0;
                    // Bus is only trusted in the final low cycle of each pulse.
`ifdef INTA_MCS80_MODE_EN
                    if (mode_q) begin
                        case (pulse_q)
                            2'd0:    err_d = (internal_data_bus != CALL_OPCODE);
                            2'd1:    call_d[7:0] = internal_data_bus;
                            default: begin
                                call_d[15:8] = internal_data_bus;
                                vector_d     = internal_data_bus;
                            end
                        endcase
                    end else if (pulse_q == 2'd1) begin
                        vector_d = internal_data_bus;
                    end
`else
                    if (pulse_q == 2'd1) begin
                        vector_d = internal_data_bus;
                    end
`endif
                    if (last_pulse) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACK_GAP;
                        pulse_d = pulse_q + 2'd1;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ACK_GAP: begin
                if (phase_q == GAP_LAST) begin
                    phase_d = 4'd0;
                    state_d = ACK_LOW;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            DONE: begin
                if (vector_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they change cleanly on the edge.
        inta_n_d = (state_d != ACK_LOW);
        valid_d  = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pulse_q  <= 2'd0;
            phase_q  <= 4'd0;
            inta_n_q <= 1'b1;
            vector_q <= 8'h00;
            valid_q  <= 1'b0;
`ifdef INTA_MCS80_MODE_EN
            mode_q   <= 1'b0;
            call_q   <= 16'h0000;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            phase_q  <= phase_d;
            inta_n_q <= inta_n_d;
            vector_q <= vector_d;
            valid_q  <= valid_d;
`ifdef INTA_MCS80_MODE_EN
            mode_q   <= mode_d;
            call_q   <= call_d;
            err_q    <= err_d;
`endif
        end
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign vector_number           = vector_q;
    assign vector_valid            = valid_q;
    assign busy                    = (state_q != IDLE);
`ifdef INTA_MCS80_MODE_EN
    assign call_address            = call_q;
    assign call_opcode_error       = err_q;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed scenarios then random traffic against an offset-based timing model.
module tb_inta_sequencer;

    localparam int PW = 2;
    localparam int GW = 1;

    logic        clock;
    logic        reset;
    logic        interrupt_to_cpu;
    logic        interrupt_enable;
    logic [7:0]  internal_data_bus;
    logic        vector_ack;
    logic        interrupt_acknowledge_n;
    logic [7:0]  vector_number;
    logic        vector_valid;
    logic        busy;
`ifdef INTA_MCS80_MODE_EN
    logic        mcs80_mode;
    logic [15:0] call_address;
    logic        call_opcode_error;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: m_t is the cycle offset inside a running sequence (0 = not running).
    int          m_t    = 0;
    int          m_np   = 2;
    bit          m_done = 0;
    logic [7:0]  m_vec  = 8'h00;

    inta_sequencer #(.PULSE_WIDTH(PW), .GAP_WIDTH(GW)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .interrupt_to_cpu        (interrupt_to_cpu),
        .interrupt_enable        (interrupt_enable),
        .internal_data_bus       (internal_data_bus),
        .vector_ack              (vector_ack),
`ifdef INTA_MCS80_MODE_EN
        .mcs80_mode              (mcs80_mode),
        .call_address            (call_address),
        .call_opcode_error       (call_opcode_error),
`endif
        .interrupt_acknowledge_n (interrupt_acknowledge_n),
        .vector_number           (vector_number),
        .vector_valid            (vector_valid),
        .busy                    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int seq_len();
        return m_np * PW + (m_np - 1) * GW;
    endfunction

    function automatic logic exp_inta_n();
        if (m_t == 0) return 1'b1;
        return (((m_t - 1) % (PW + GW)) < PW) ? 1'b0 : 1'b1;
    endfunction

    task automatic model_step(input logic i_int, input logic i_ie, input logic [7:0] i_bus,
                              input logic i_ack, input logic i_rst);
        if (i_rst) begin
            m_t = 0; m_done = 0; m_vec = 8'h00; m_np = 2;
        end else if (m_done) begin
            if (i_ack) m_done = 0;
        end else if (m_t == 0) begin
            if (i_int && i_ie) begin
                m_t  = 1;
                m_np = 2;
`ifdef INTA_MCS80_MODE_EN
                if (mcs80_mode) m_np = 3;
`endif
            end
        end else if (m_t == seq_len()) begin
            m_vec  = i_bus;
            m_done = 1;
            m_t    = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic cyc(input logic i_int, input logic i_ie, input logic [7:0] i_bus,
                       input logic i_ack, input logic i_rst);
        interrupt_to_cpu  = i_int;
        interrupt_enable  = i_ie;
        internal_data_bus = i_bus;
        vector_ack        = i_ack;
        reset             = i_rst;
        @(posedge clock);
        #1;
        model_step(i_int, i_ie, i_bus, i_ack, i_rst);
        chk("inta_n", interrupt_acknowledge_n, exp_inta_n());
        chk("busy",   busy,          (m_t != 0 || m_done) ? 1 : 0);
        chk("valid",  vector_valid,  m_done ? 1 : 0);
        chk("vector", vector_number, m_vec);
    endtask

    logic [7:0] bus_seq [0:5];

    initial begin
`ifdef INTA_MCS80_MODE_EN
        mcs80_mode = 1'b0;
`endif
        // Reset state
        cyc(1, 1, 8'h00, 0, 1);
        cyc(1, 1, 8'h00, 0, 1);
        chk("rst_inta_n", interrupt_acknowledge_n, 1);
        chk("rst_busy",   busy, 0);
        chk("rst_valid",  vector_valid, 0);
        chk("rst_vector", vector_number, 8'h00);

        // Basic 8086 sequence: pulse-1 byte must be discarded, bus 0x4B on cycle 5
        bus_seq[0] = 8'h11; bus_seq[1] = 8'h22; bus_seq[2] = 8'h99;
        bus_seq[3] = 8'h33; bus_seq[4] = 8'h44; bus_seq[5] = 8'h4B;
        cyc(1, 1, bus_seq[0], 0, 0);
        chk("c1_inta_n", interrupt_acknowledge_n, 0);
        cyc(1, 1, bus_seq[1], 0, 0);
        chk("c2_inta_n", interrupt_acknowledge_n, 0);
        cyc(1, 1, bus_seq[2], 0, 0);
        chk("c3_inta_n", interrupt_acknowledge_n, 1);
        cyc(1, 1, bus_seq[3], 0, 0);
        chk("c4_inta_n", interrupt_acknowledge_n, 0);
        cyc(1, 1, bus_seq[4], 0, 0);
        chk("c5_inta_n", interrupt_acknowledge_n, 0);
        chk("c5_valid",  vector_valid, 0);
        cyc(1, 1, bus_seq[5], 0, 0);
        chk("c6_inta_n", interrupt_acknowledge_n, 1);
        chk("c6_valid",  vector_valid, 1);
        chk("c6_vector", vector_number, 8'h4B);

        // Vector held through 10 un-acked cycles, ack returns to idle
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 8'($urandom), 0, 0);
            chk("hold_valid",  vector_valid, 1);
            chk("hold_vector", vector_number, 8'h4B);
            chk("hold_inta_n", interrupt_acknowledge_n, 1);
        end
        cyc(1, 1, 8'h00, 1, 0);
        chk("ack_valid",  vector_valid, 0);
        chk("ack_busy",   busy, 0);
        chk("ack_inta_n", interrupt_acknowledge_n, 1);
        cyc(1, 1, 8'h00, 0, 0);
        chk("restart_inta_n", interrupt_acknowledge_n, 0);

        // Reset then INT with IE low: nothing happens
        cyc(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 8'($urandom), (i % 3) == 0, 0);
            chk("noie_inta_n", interrupt_acknowledge_n, 1);
            chk("noie_busy",   busy, 0);
        end

        // Reset during the second low pulse
        for (int i = 0; i < 4; i++) cyc(1, 1, 8'h5A, 0, 0);
        chk("mid_inta_n_low", interrupt_acknowledge_n, 0);
        cyc(1, 1, 8'h5A, 0, 1);
        chk("midrst_inta_n", interrupt_acknowledge_n, 1);
        chk("midrst_busy",   busy, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 8'h5A, 0, 0);
            chk("midrst_no_valid", vector_valid, 0);
        end

        // INT dropped during the first gap: sequence still completes
        cyc(1, 1, 8'h01, 0, 0);
        cyc(1, 1, 8'h02, 0, 0);
        cyc(0, 0, 8'h03, 0, 0);
        chk("drop_gap_inta_n", interrupt_acknowledge_n, 1);
        cyc(0, 0, 8'h04, 0, 0);
        chk("drop_p2_inta_n", interrupt_acknowledge_n, 0);
        cyc(0, 0, 8'h05, 0, 0);
        cyc(0, 0, 8'hE7, 0, 0);
        chk("drop_valid",  vector_valid, 1);
        chk("drop_vector", vector_number, 8'hE7);
        cyc(0, 0, 8'h00, 1, 0);

`ifdef INTA_MCS80_MODE_EN
        // MCS-80 CALL sequence, good opcode then bad opcode
        for (int pass = 0; pass < 2; pass++) begin
            cyc(0, 0, 8'h00, 0, 1);
            mcs80_mode = 1'b1;
            for (int c = 0; c < 9; c++) begin
                cyc(1, 1, (c == 2) ? ((pass == 0) ? 8'hCD : 8'hCC) :
                          (c == 5) ? 8'h20 : (c == 8) ? 8'h01 : 8'h55, 0, 0);
                mcs80_mode = 1'b0;
            end
            chk("mcs_valid",  vector_valid, 1);
            chk("mcs_vector", vector_number, 8'h01);
            chk("mcs_call",   call_address, 16'h0120);
            chk("mcs_err",    call_opcode_error, (pass == 0) ? 0 : 1);
            cyc(0, 0, 8'h00, 1, 0);
        end
        mcs80_mode = 1'b0;
`endif

        // Random traffic against the model
        cyc(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 8'($urandom),
                $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
